str_cic_upsampler: RTL and testbench
====================================

# str_cic_upsampler

Streaming CIC interpolator: accepts one sample per valid/ready handshake and emits R output samples per input, low-pass filtered and gain-normalised. It is the transmit-side counterpart of the streaming CIC decimator in the LPDAQ data path. Cascade order: N combs at input rate, then an R-fold zero-stuffing expander, then N integrators at output rate, then a fixed-point attenuator. Every stage is a one-deep registered valid/ready slice.

## Interface

- W, 16: input/output sample width (signed two's complement)
- R, 4: interpolation rate, ≥1
- M, 1: differential delay of each comb, ≥1
- N, 2: number of comb/integrator stages, ≥1

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  W  input sample, signed
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  W  output sample, signed
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready

## Operation

- Internal width DW = W + clog2((R·M)^N); input sign-extended to DW. All stage arithmetic is DW-bit wrap-around modular; wrap is intentional and cancels across the cascade.
- Stage slice rule (combs, expander output register, integrators): ish = ivalid&iready, osh = ovalid&oready, iready = osh | ~ovalid; ovalid set on ish, cleared on osh without ish; data register loads only on ish.
- Comb k: on ish, out <= in − dly[M−1]; delay line shifts in `in` (dly[0] <= in). Delay line resets to zero.
- Expander: phase counter cnt in 0..R−1, reset 0. Free slot = osh | ~ovalid.
  - cnt==0 and free: iready=1; on ish out <= in, ovalid <= 1, cnt <= (R>1 ? 1 : 0).
  - cnt!=0 and free: out <= 0, ovalid <= 1, cnt <= cnt+1 wrapping to 0 after R−1; upstream iready=0.
  - cnt!=0 and not free: hold everything.
- Integrator k: on ish, out <= out + in (accumulator resets 0).
- Gain GAIN = (R·M)^N / R. attn = floor(2^(DW−1) / GAIN) as DW-bit Q1.(DW−1). m_axis_tdata = low W bits of ((2·DW)-bit product of last integrator output and attn) >>> (DW−1), arithmetic shift. Combinational from last integrator register.
- m_axis_tvalid = last integrator ovalid; last integrator oready = m_axis_tready.
- Boundary: R=1 → expander is a plain slice; M=1 → single-register delay line. s_axis_tvalid without ready: no state change. Data and valid held stable while m_axis_tready=0.

## Timing

- Reset: all ovalid 0, all data, delays, accumulators, cnt 0; m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=1 the cycle after reset release.
- Latency, ready always high: input accepted at cycle t → first of its R outputs valid at t+2N+1; remaining R−1 on consecutive cycles.
- Throughput: one input per R cycles; s_axis_tready high exactly one cycle in R under continuous flow.
- Backpressure: any cycle m_axis_tready=0 stalls the whole cascade without loss or duplication; sample sequence identical to unstalled run.
- rst_n low mid-stream: all state cleared next edge regardless of handshakes; partially emitted zero bursts are discarded.

## Structure

- Package cic_pkg: function cic_dw(W,R,M,N), function cic_attn(DW,R,M,N), shared slice handshake helpers if any.
- Sub-module str_zero_stuff (W=DW, R): the expander with its phase counter. Combs and integrators are instantiated as the codebase's existing streaming comb and integrator stages at width DW; top-level generate loops chain them.

## Test plan

- W=16,R=4,M=1,N=2 (DW=20, attn=131072): constant input 1000, oready=1 → after settling, every output = 1000.
- Same config, impulse 4096 then zeros → outputs from cycle 2N+1: 1024,2048,3072,4096,3072,2048,1024, then 0.
- Continuous valid, oready=1 → s_axis_tready pulses 1-in-4; exactly 4 outputs per accepted input; first output exactly 5 cycles after first accept.
- Random oready (50%) on impulse test → output sequence identical to unstalled; m_axis_tdata stable while valid & !ready.
- Full-scale alternating ±32767 input for 1000 samples → no mismatch vs. bit-accurate model despite internal wrap.
- rst_n low for one cycle mid-burst (cnt=2) → next cycle all valids 0, s_axis_tready=1; subsequent step response matches fresh-reset run.

Source files
------------

// File: rtl/cic_pkg.sv
// cic_pkg: width-growth and gain-normalisation helpers for the streaming CIC stages
package cic_pkg;

    function automatic longint cic_growth(input int r, input int m, input int n);
        longint g = 1;
        for (int i = 0; i < n; i++) g = g * longint'(r * m);
        return g;
    endfunction

    function automatic int cic_dw(input int w, input int r, input int m, input int n);
        longint g = cic_growth(r, m, n);
        int b = 0;
        while ((longint'(1) << b) < g) b++;
        return w + b;
    endfunction

    // Q1.(DW-1) reciprocal of the interpolator DC gain (RM)^N / R
    function automatic longint cic_attn(input int dw, input int r, input int m, input int n);
        return (longint'(1) << (dw - 1)) / (cic_growth(r, m, n) / longint'(r));
    endfunction

endpackage

// File: rtl/str_comb.sv
// str_comb: streaming comb stage, out = in minus the input M accepted samples earlier
module str_comb #(
    parameter int DW = 20,
    parameter int M  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);
    logic [DW-1:0] dly [M];
    logic ish;

    assign s_ready = (m_valid & m_ready) | ~m_valid;
    assign ish = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data <= '0;
            for (int i = 0; i < M; i++) dly[i] <= '0;
        end else begin
            if (ish) begin
                m_data <= s_data - dly[M-1];
                dly[0] <= s_data;
                for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
            end
            m_valid <= ish | (m_valid & ~m_ready);
        end
    end

endmodule

// File: rtl/str_integrator.sv
// str_integrator: streaming integrator stage, accumulates every accepted sample
module str_integrator #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);
    logic ish;

    assign s_ready = (m_valid & m_ready) | ~m_valid;
    assign ish = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data <= '0;
        end else begin
            if (ish) m_data <= m_data + s_data;
            m_valid <= ish | (m_valid & ~m_ready);
        end
    end

endmodule

// File: rtl/str_zero_stuff.sv
// str_zero_stuff: R-fold expander, emits each input followed by R-1 zeros
module str_zero_stuff #(
    parameter int W = 20,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);
    localparam int CW = R > 1 ? $clog2(R) : 1;

    logic [CW-1:0] cnt;
    logic free;

    assign free = m_ready | ~m_valid;
    assign s_ready = free & (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data <= '0;
            cnt <= '0;
        end else if (free) begin
            if (cnt != '0) begin
                m_data <= '0;
                m_valid <= 1'b1;
                cnt <= cnt == CW'(R - 1) ? '0 : cnt + 1'b1;
            end else if (s_valid) begin
                m_data <= s_data;
                m_valid <= 1'b1;
                cnt <= CW'(R > 1);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/str_cic_upsampler.sv
// str_cic_upsampler: N combs, R-fold expander, N integrators, then gain normalisation
module str_cic_upsampler
    import cic_pkg::*;
#(
    parameter int W = 16,
    parameter int R = 4,
    parameter int M = 1,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready
);
    localparam int DW = cic_dw(W, R, M, N);
    localparam logic [DW-1:0] ATTN = DW'(cic_attn(DW, R, M, N));

    logic [DW-1:0] c_data [N+1];
    logic          c_valid [N+1];
    logic          c_ready [N+1];
    logic [DW-1:0] i_data [N+1];
    logic          i_valid [N+1];
    logic          i_ready [N+1];

    assign c_data[0] = DW'($signed(s_axis_tdata));
    assign c_valid[0] = s_axis_tvalid;
    assign s_axis_tready = c_ready[0];

    for (genvar k = 0; k < N; k++) begin : g_comb
        str_comb #(.DW(DW), .M(M)) u_comb (
            .clk(clk), .rst_n(rst_n),
            .s_data(c_data[k]), .s_valid(c_valid[k]), .s_ready(c_ready[k]),
            .m_data(c_data[k+1]), .m_valid(c_valid[k+1]), .m_ready(c_ready[k+1])
        );
    end

    str_zero_stuff #(.W(DW), .R(R)) u_stuff (
        .clk(clk), .rst_n(rst_n),
        .s_data(c_data[N]), .s_valid(c_valid[N]), .s_ready(c_ready[N]),
        .m_data(i_data[0]), .m_valid(i_valid[0]), .m_ready(i_ready[0])
    );

    for (genvar k = 0; k < N; k++) begin : g_integ
        str_integrator #(.DW(DW)) u_integ (
            .clk(clk), .rst_n(rst_n),
            .s_data(i_data[k]), .s_valid(i_valid[k]), .s_ready(i_ready[k]),
            .m_data(i_data[k+1]), .m_valid(i_valid[k+1]), .m_ready(i_ready[k+1])
        );
    end

    assign m_axis_tvalid = i_valid[N];
    assign i_ready[N] = m_axis_tready;
    // attn is zero-extended so a gain of one (attn = 2^(DW-1)) stays positive
    assign m_axis_tdata = W'((((2 * DW)'($signed(i_data[N]))) * $signed((2 * DW)'(ATTN))) >>> (DW - 1));

endmodule

// File: tb/tb_str_cic_upsampler.sv
// tb_str_cic_upsampler: scoreboard bench with hand-derived vectors and a sample-level CIC model
module tb_str_cic_upsampler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic m_axis_tvalid;
    logic m_axis_tready = 1'b1;

    typedef struct packed {
        logic [15:0] x;
        logic [3:0][15:0] e;
    } vec_t;

    vec_t tab [9];
    logic [15:0] exp_q [$];
    logic [19:0] c1 = '0, c2 = '0, a1 = '0, a2 = '0;
    int tests = 0, fails = 0, cyc = 0;
    int acc_cyc = 0, first_out = -1, first_acc = 0, prev_acc = 0;
    bit rnd_rdy = 1'b0;
    bit held = 1'b0;
    logic [15:0] held_data = '0;

    str_cic_upsampler #(.W(16), .R(4), .M(1), .N(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input int x, input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.x = 16'(x);
        v.e[0] = 16'(e0);
        v.e[1] = 16'(e1);
        v.e[2] = 16'(e2);
        v.e[3] = 16'(e3);
        return v;
    endfunction

    // output = integrator * 131072 >>> 19
    function automatic logic [15:0] scale(input logic [19:0] v);
        longint p = longint'($signed(v)) * 131072;
        return 16'(p >>> 19);
    endfunction

    task automatic model_run(input logic [15:0] x, output logic [3:0][15:0] e);
        logic [19:0] xe, d1, d2;
        xe = {{4{x[15]}}, x};
        d1 = xe - c1;
        c1 = xe;
        d2 = d1 - c2;
        c2 = d1;
        for (int p = 0; p < 4; p++) begin
            a1 = a1 + (p == 0 ? d2 : 20'd0);
            a2 = a2 + a1;
            e[p] = scale(a2);
        end
    endtask

    task automatic send(input logic [15:0] x, input bit use_tab, input logic [3:0][15:0] te);
        logic [3:0][15:0] me;
        bit hs = 1'b0;
        s_axis_tdata = x;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = s_axis_tready;
            if (hs) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        if (!hs) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout got no ready expected ready within 100 cycles");
            return;
        end
        model_run(x, me);
        for (int p = 0; p < 4; p++) exp_q.push_back(use_tab ? te[p] : me[p]);
    endtask

    task automatic clear_model();
        exp_q.delete();
        c1 = '0;
        c2 = '0;
        a1 = '0;
        a2 = '0;
        first_out = -1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", int'(m_axis_tvalid), 1);
                check("hold_data", int'($signed(m_axis_tdata)), int'($signed(held_data)));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (first_out < 0) first_out = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_out got %0d expected no output", $signed(m_axis_tdata));
                end else begin
                    check("out", int'($signed(m_axis_tdata)), int'($signed(exp_q.pop_front())));
                end
            end
            held = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
        end
    end

    initial begin
        tab[0] = mk(4096, 1024, 2048, 3072, 4096);
        tab[1] = mk(0, 3072, 2048, 1024, 0);
        tab[2] = mk(0, 0, 0, 0, 0);
        tab[3] = mk(1000, 250, 500, 750, 1000);
        tab[4] = mk(1000, 1000, 1000, 1000, 1000);
        tab[5] = mk(1000, 1000, 1000, 1000, 1000);
        tab[6] = mk(-2000, 250, -500, -1250, -2000);
        tab[7] = mk(-2000, -2000, -2000, -2000, -2000);
        tab[8] = mk(-2000, -2000, -2000, -2000, -2000);

        do_reset(3);
        @(negedge clk);
        check("rst_m_valid", int'(m_axis_tvalid), 0);
        check("rst_m_data", int'(m_axis_tdata), 0);
        check("rst_s_ready", int'(s_axis_tready), 1);
        @(posedge clk);
        #1;

        // continuous flow: latency and 1-in-4 acceptance
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom_range(0, 65535)), 1'b0, '0);
            if (i == 0) first_acc = acc_cyc;
            if (i >= 4) check("accept_gap", acc_cyc - prev_acc, 4);
            prev_acc = acc_cyc;
        end
        check("first_latency", first_out - first_acc, 5);
        drain();

        do_reset(2);
        for (int i = 0; i < 9; i++) send(tab[i].x, 1'b1, tab[i].e);
        drain();

        do_reset(2);
        rnd_rdy = 1'b1;
        for (int i = 0; i < 9; i++) send(tab[i].x, 1'b1, tab[i].e);
        drain();

        do_reset(2);
        for (int i = 0; i < 1000; i++) send(i % 2 ? 16'h8001 : 16'h7fff, 1'b0, '0);
        drain();
        rnd_rdy = 1'b0;

        // reset while the expander is emitting the zero burst of a sample
        do_reset(2);
        @(posedge clk);
        #1;
        send(16'd1000, 1'b0, '0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        check("mid_rst_m_valid", int'(m_axis_tvalid), 0);
        check("mid_rst_m_data", int'(m_axis_tdata), 0);
        check("mid_rst_s_ready", int'(s_axis_tready), 1);
        @(posedge clk);
        #1;
        for (int i = 3; i < 9; i++) send(tab[i].x, 1'b1, tab[i].e);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
